uart_receiver: RTL

- Receive side of the board UART link; complements the transmit path.
- Deserialises 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) from the UART_RX pin.
- Presents each byte to the CPU peripheral bus with a one-cycle RX_STATUS strobe.
- Generates its own 16x oversampling tick from sysclk; needs no external baud clock.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_tick_gen.sv | 31 +++
 rtl/uart_receiver.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned MID_TICK  = 7;
    localparam int unsigned LAST_TICK = 15;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIV sysclk cycles while run is high.
module uart_rx_tick_gen #(
    parameter int unsigned DIV = 651
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic          at_top;

    assign at_top = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear || !run || at_top) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = run && !clear && at_top;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, start-glitch rejection and framing-error/break handling.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV        = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_BUSY,
    output logic       FRAME_ERR
);

    rx_state_e  state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [3:0] samp_cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q, data_q;
    logic       status_q, ferr_q;
    logic       tick, start_det, mid_samp, bit_samp, stop_samp, busy;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    uart_rx_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .sysclk(sysclk),
        .reset (reset),
        .clear (start_det),
        .run   (busy),
        .tick  (tick)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rx_s_q) state_d = START;
            START:   if (mid_samp) state_d = rx_s_q ? IDLE : DATA;
            DATA:    if (bit_samp && bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
            STOP:    if (stop_samp) state_d = rx_s_q ? IDLE : BREAK;
            BREAK:   if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        start_det = (state_q == IDLE) && !rx_s_q;
        mid_samp  = (state_q == START) && tick && (samp_cnt_q == 4'(MID_TICK));
        bit_samp  = (state_q == DATA) && tick && (samp_cnt_q == 4'(LAST_TICK));
        stop_samp = (state_q == STOP) && tick && (samp_cnt_q == 4'(LAST_TICK));
    end

    // The sample counter restarts at mid start bit so later samples land mid-bit.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            status_q   <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (start_det || mid_samp) begin
                samp_cnt_q <= '0;
            end else if (tick) begin
                samp_cnt_q <= samp_cnt_q + 4'd1;
            end
            if (mid_samp) begin
                bit_idx_q <= '0;
            end else if (bit_samp) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (bit_samp) begin
                shift_q[bit_idx_q] <= rx_s_q;
            end
            if (stop_samp && rx_s_q) begin
                data_q <= shift_q;
            end
            status_q <= stop_samp && rx_s_q;
            ferr_q   <= stop_samp && !rx_s_q;
        end
    end

    assign RX_DATA   = data_q;
    assign RX_STATUS = status_q;
    assign FRAME_ERR = ferr_q;
    assign RX_BUSY   = busy;

endmodule
